rr_arb_ctrl: RTL and testbench

Round-robin controller that shares one sequential datapath unit (a small Mealy FSM engine) between N_REQ requesters.
- Requesters use a req/done handshake; the block issues a registered one-hot grant.
- It guarantees one idle cycle between consecutive owners.
- It sits between the requester clients and the shared engine's enable/select inputs.

---
 rtl/rr_arb_pkg.sv | 19 +
 rtl/rr_arb_pick.sv | 31 +++
 rtl/rr_arb_ctrl.sv | 121 ++++++++++++
 tb/tb_rr_arb_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter controller.
// States are one-cold; onehot() builds a grant vector from an index.
package rr_arb_pkg;

  localparam int STATE_W      = 3;
  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 15;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'b011,
    GRANT = 3'b101,
    REL   = 3'b110
  } state_e;

  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotating priority encoder.
// The search starts one past ptr_i and wraps, so ptr_i itself has lowest priority.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int OW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [OW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [OW-1:0]    win_o
);

  logic [OW-1:0] idx;

  // Scan from farthest to nearest so the nearest set bit is the last one written.
  always_comb begin
    valid_o = 1'b0;
    win_o   = '0;
    idx     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = OW'((int'(ptr_i) + i) % N_REQ);
      if (req_i[idx]) begin
        valid_o = 1'b1;
        win_o   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_ctrl.sv
// Round-robin owner controller for a shared engine: registered one-hot grant,
// one idle cycle between owners. Define RR_TIMEOUT_EN to add a forced release after MAX_HOLD cycles.
module rr_arb_ctrl
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ    = DEF_N_REQ,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int OW       = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [OW-1:0]    owner_o,
  output logic             busy_o,
  output logic             timeout_o
);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic              pickValid;
  logic [OW-1:0]     pickWin;
  logic              ownerRel;
  logic              holdLimit;

  rr_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pickValid),
    .win_o   (pickWin)
  );

  assign ownerRel = !req_i[owner_q] || done_i[owner_q];

`ifdef RR_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] holdCnt_q, holdCnt_d;
  logic          timeout_q, timeout_d;

  assign holdLimit = (state_q == GRANT) && (holdCnt_q == CW'(MAX_HOLD - 1));

  // Counter idles at zero outside GRANT; a voluntary release at the limit wins over the timeout.
  always_comb begin
    holdCnt_d = '0;
    timeout_d = 1'b0;
    if (state_q == GRANT) begin
      holdCnt_d = holdCnt_q + 1'b1;
      timeout_d = holdLimit && !ownerRel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign holdLimit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE, REL: begin
        if (pickValid) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(onehot(32'(pickWin)));
          owner_d = pickWin;
          ptr_d   = pickWin;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (ownerRel || holdLimit) begin
          state_d = REL;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Pointer resets to the last requester so requester 0 is served first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign busy_o  = |gnt_q;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Self-checking bench for rr_arb_ctrl: directed scenarios plus randomized traffic
// against a behavioural owner/pointer model. Timeout checks follow RR_TIMEOUT_EN.
module tb_rr_arb_ctrl;

  localparam int N    = 4;
  localparam int MAXH = 15;
`ifdef RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Model: mOwner is -1 while nobody holds the grant.
  int mOwner;
  int mPtr;
  int mOwnOut;
  int mHold;
  bit mTo;

  always #5 clk = ~clk;

  rr_arb_ctrl #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .owner_o   (owner),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  function automatic void modelReset();
    mOwner  = -1;
    mPtr    = N - 1;
    mOwnOut = 0;
    mHold   = 0;
    mTo     = 1'b0;
  endfunction

  // A release always leaves the grant free for one edge, which yields the idle gap.
  function automatic void modelEdge();
    int c;
    if (rst) begin
      modelReset();
      return;
    end
    mTo = 1'b0;
    if (mOwner >= 0) begin
      if (!req[mOwner] || done[mOwner]) mOwner = -1;
      else if (TO_EN && mHold >= MAXH) begin
        mOwner = -1;
        mTo    = 1'b1;
      end else mHold++;
    end else begin
      for (int i = 1; i <= N; i++) begin
        c = (mPtr + i) % N;
        if (req[c]) begin
          mOwner  = c;
          mPtr    = c;
          mOwnOut = c;
          mHold   = 1;
          break;
        end
      end
    end
  endfunction

  function automatic logic [3:0] expGnt();
    return (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyReset();
    rst  = 1'b1;
    done = 4'b0000;
    modelReset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b1111;
    done = 4'b0000;
    modelReset();
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout); end
    rst = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL idle_gnt[%0d]: got %b expected 0000", i, gnt); end
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL single_gnt: got %b expected 0100", gnt); end
    checks++; if (owner !== 2'd2) begin failures++; $display("[TB] FAIL single_owner: got %0d expected 2", owner); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    done = 4'b0100;
    tick();
    done = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL single_rel_gap: got %b expected 0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL single_regrant: got %b expected 0100", gnt); end
    done = 4'b0001;
    tick();
    done = 4'b0000;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL foreign_done_ignored: got %b expected 0100", gnt); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL req_drop_release: got %b expected 0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL idle_after_drop: got %b expected 0000", gnt); end
  endtask

  task automatic test_round_robin();
    int order [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3};
    applyReset();
    req = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req = 4'b1001;
      tick();
      checks++; if (gnt !== 4'(1 << order[k])) begin failures++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, gnt, 4'(1 << order[k])); end
      checks++; if (owner !== 2'(order[k])) begin failures++; $display("[TB] FAIL rr_owner[%0d]: got %0d expected %0d", k, owner, order[k]); end
      tick();
      checks++; if (gnt !== 4'(1 << order[k])) begin failures++; $display("[TB] FAIL rr_hold[%0d]: got %b expected %b", k, gnt, 4'(1 << order[k])); end
      done = 4'(1 << order[k]);
      tick();
      done = 4'b0000;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL rr_gap[%0d]: got %b expected 0000", k, gnt); end
    end
  endtask

  task automatic test_reset_mid_grant();
    applyReset();
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL mid_pre_gnt: got %b expected 0010", gnt); end
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL mid_async_gnt: got %b expected 0000", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_busy: got %b expected 0", busy); end
    #1;
    rst = 1'b0;
    // With the pointer back at 3, requester 1 beats requester 3.
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL mid_regrant_gnt: got %b expected 0010", gnt); end
    checks++; if (owner !== 2'd1) begin failures++; $display("[TB] FAIL mid_regrant_owner: got %0d expected 1", owner); end
  endtask

  task automatic test_timeout();
    int held;
    applyReset();
    req = 4'b0011;
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL to_first_gnt: got %b expected 0001", gnt); end
`ifdef RR_TIMEOUT_EN
    held = 0;
    for (int c = 0; c < 40 && gnt === 4'b0001; c++) begin
      held++;
      checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL to_early_pulse[%0d]: got %b expected 0", c, timeout); end
      tick();
    end
    checks++; if (held !== MAXH) begin failures++; $display("[TB] FAIL to_hold_len: got %0d expected %0d", held, MAXH); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL to_rel_gnt: got %b expected 0000", gnt); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("[TB] FAIL to_pulse: got %b expected 1", timeout); end
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL to_next_gnt: got %b expected 0010", gnt); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL to_pulse_end: got %b expected 0", timeout); end
`else
    held = 1;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (gnt === 4'b0001) held++;
      checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL nto_timeout[%0d]: got %b expected 0", c, timeout); end
    end
    checks++; if (held !== 46) begin failures++; $display("[TB] FAIL nto_hold_len: got %0d expected 46", held); end
`endif
  endtask

  task automatic test_done_at_limit();
    applyReset();
    req = 4'b0001;
    tick();
    repeat (MAXH - 1) tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL lim_still_held: got %b expected 0001", gnt); end
    done = 4'b0001;
    tick();
    done = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL lim_release: got %b expected 0000", gnt); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL lim_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_random();
    applyReset();
    req = 4'($urandom);
    for (int c = 0; c < 500; c++) begin
      tick();
      checks++; if (gnt !== expGnt()) begin failures++; $display("[TB] FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt, expGnt()); end
      checks++; if (owner !== 2'(mOwnOut)) begin failures++; $display("[TB] FAIL rnd_owner[%0d]: got %0d expected %0d", c, owner, mOwnOut); end
      checks++; if (busy !== (mOwner >= 0)) begin failures++; $display("[TB] FAIL rnd_busy[%0d]: got %b expected %b", c, busy, (mOwner >= 0)); end
      checks++; if (timeout !== mTo) begin failures++; $display("[TB] FAIL rnd_timeout[%0d]: got %b expected %b", c, timeout, mTo); end
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      done = 4'b0000;
      if (mOwner >= 0 && $urandom_range(0, 11) == 0) done[mOwner] = 1'b1;
      if ($urandom_range(0, 5) == 0) done[$urandom_range(0, N - 1)] = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reset_mid_grant();
    test_timeout();
    test_done_at_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
